// File: rtl/fmo_acc_ram.sv
// fmo_acc_ram: output feature-map buffer between the PE array output stage and the
// DMA write-back path.
//
// Each memory word holds LANES signed pixels of PX_W bits; lane i is at bits
// [i*PX_W +: PX_W]. Writes go through a two-stage pipeline:
//   - The sampling edge captures the request and the current word. That word comes
//     from the array, or from the pending write when it targets the same address.
//   - The next edge writes the merged word back.
// Accumulate writes add per lane with saturation. Accumulation across input-channel
// tiles needs no external read-back, and back-to-back writes to one address chain
// without stalling. A clear sequencer zeroes one word per cycle while busy_o is high.
//
// Ports
//   clk_i       clock, all logic on the rising edge
//   rst_i       synchronous active-high reset (array contents are kept)
//   clr_i       pulse: start zeroing the whole array (ignored while busy)
//   busy_o      high while the clear sequence runs
//   wr_en_i     write request
//   wr_acc_i    1: mem += data (saturating), 0: mem = data
//   wr_mask_i   per-lane write enable
//   wr_addr_i   write word address
//   wr_data_i   write / addend data
//   rd_en_i     read request
//   rd_addr_i   read word address
//   rd_data_o   read data, held until the next accepted read
//   rd_valid_o  one-cycle pulse, one cycle after an accepted read
//   sat_flag_o  sticky: some accumulate saturated (cleared by reset or clr_i)
module fmo_acc_ram #(
  parameter int unsigned PX_W  = 16,
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned WW   = LANES * PX_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  output logic             busy_o,
  input  logic             wr_en_i,
  input  logic             wr_acc_i,
  input  logic [LANES-1:0] wr_mask_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WW-1:0]    wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WW-1:0]    rd_data_o,
  output logic             rd_valid_o,
  output logic             sat_flag_o
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  localparam logic [AW-1:0]   LastAddr = AW'(DEPTH - 1);
  localparam logic [PX_W-1:0] PxMax    = {1'b0, {(PX_W - 1){1'b1}}};
  localparam logic [PX_W-1:0] PxMin    = {1'b1, {(PX_W - 1){1'b0}}};

  // Storage array (no reset: contents survive rst_i).
  logic [WW-1:0] mem_q [DEPTH];

  // Sequencer state
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Pending write (stage 2): request plus the word it merges into
  logic             pw_valid_q, pw_valid_d;
  logic [AW-1:0]    pw_addr_q, pw_addr_d;
  logic [LANES-1:0] pw_mask_q, pw_mask_d;
  logic             pw_acc_q, pw_acc_d;
  logic [WW-1:0]    pw_data_q, pw_data_d;
  logic [WW-1:0]    pw_old_q, pw_old_d;

  // Read port and flags
  logic          rd_valid_q, rd_valid_d;
  logic [WW-1:0] rd_data_q, rd_data_d;
  logic          sat_q, sat_d;

  // Decoded controls
  logic          idle;
  logic          clr_start;
  logic          wr_accept;
  logic          rd_accept;

  // Merge datapath
  logic [WW-1:0] merged;
  logic          pw_sat;
  logic [PX_W:0] lane_sum;

  // Forwarding and array write port
  logic          wr_fwd;
  logic          rd_fwd;
  logic [WW-1:0] old_word;
  logic [WW-1:0] rd_word;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [WW-1:0] mem_wdata;

  assign idle      = (state_q == StIdle);
  // Requests coinciding with clr_i are dropped; everything is ignored during a clear.
  assign clr_start = idle & clr_i;
  assign wr_accept = idle & ~clr_i & wr_en_i;
  assign rd_accept = idle & ~clr_i & rd_en_i;

  // Per-lane merge of the pending write. The sum is formed one bit wider; a carry
  // that disagrees with the sign bit means overflow, and the wide sign picks the rail.
  always_comb begin
    merged   = pw_old_q;
    pw_sat   = 1'b0;
    lane_sum = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (pw_mask_q[i]) begin
        if (pw_acc_q) begin
          lane_sum = {pw_old_q[i*PX_W + PX_W - 1], pw_old_q[i*PX_W +: PX_W]}
                   + {pw_data_q[i*PX_W + PX_W - 1], pw_data_q[i*PX_W +: PX_W]};
          if (lane_sum[PX_W] != lane_sum[PX_W-1]) begin
            pw_sat                   = 1'b1;
            merged[i*PX_W +: PX_W]   = lane_sum[PX_W] ? PxMin : PxMax;
          end else begin
            merged[i*PX_W +: PX_W]   = lane_sum[PX_W-1:0];
          end
        end else begin
          merged[i*PX_W +: PX_W] = pw_data_q[i*PX_W +: PX_W];
        end
      end
    end
  end

  // The pending write commits on the coming edge, so anything sampled now must see
  // its merged result rather than the stale array word.
  assign wr_fwd   = pw_valid_q && (pw_addr_q == wr_addr_i);
  assign rd_fwd   = pw_valid_q && (pw_addr_q == rd_addr_i);
  assign old_word = wr_fwd ? merged : mem_q[wr_addr_i];
  assign rd_word  = rd_fwd ? merged : mem_q[rd_addr_i];

  // No pending write is ever valid while clearing, so the two write sources never
  // collide. The write sampled just before clr_i commits on the clr_i edge itself,
  // while still idle, and is later overwritten by the clear.
  assign mem_we    = ~idle | pw_valid_q;
  assign mem_waddr = idle ? pw_addr_q : cnt_q;
  assign mem_wdata = idle ? merged : '0;

  // Clear sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pipeline, read port and sticky flag next state
  always_comb begin
    pw_valid_d = wr_accept;
    pw_addr_d  = pw_addr_q;
    pw_mask_d  = pw_mask_q;
    pw_acc_d   = pw_acc_q;
    pw_data_d  = pw_data_q;
    pw_old_d   = pw_old_q;
    if (wr_accept) begin
      pw_addr_d = wr_addr_i;
      pw_mask_d = wr_mask_i;
      pw_acc_d  = wr_acc_i;
      pw_data_d = wr_data_i;
      pw_old_d  = old_word;
    end

    rd_valid_d = rd_accept;
    rd_data_d  = rd_accept ? rd_word : rd_data_q;

    // The flag rises on the edge that commits the saturating word; a clear start
    // wins over a saturating commit on the same edge.
    sat_d = sat_q;
    if (pw_valid_q && pw_sat) begin
      sat_d = 1'b1;
    end
    if (clr_start) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pw_valid_q <= 1'b0;
      pw_addr_q  <= '0;
      pw_mask_q  <= '0;
      pw_acc_q   <= 1'b0;
      pw_data_q  <= '0;
      pw_old_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pw_valid_q <= pw_valid_d;
      pw_addr_q  <= pw_addr_d;
      pw_mask_q  <= pw_mask_d;
      pw_acc_q   <= pw_acc_d;
      pw_data_q  <= pw_data_d;
      pw_old_q   <= pw_old_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      sat_q      <= sat_d;
    end
  end

  // Reset suppresses the write on its edge: a pending write is discarded and an
  // interrupted clear leaves the remaining words untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy_o     = ~idle;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign sat_flag_o = sat_q;

endmodule

// File: tb/tb_fmo_acc_ram.sv
// Self-checking bench for fmo_acc_ram. A behavioural model applies every accepted
// write immediately (integer lanes, clamped sums). An accepted read pushes its
// expected word into a queue, and a negedge monitor compares each rd_valid pulse
// against the queue head. busy_o and sat_flag_o are compared every cycle.
module tb_fmo_acc_ram;

  localparam int PX_W  = 16;
  localparam int LANES = 4;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int WW    = LANES * PX_W;
  localparam int PxMax = (1 << (PX_W - 1)) - 1;
  localparam int PxMin = -(1 << (PX_W - 1));

  logic             clk = 1'b0;
  logic             rst_i;
  logic             clr_i;
  logic             busy_o;
  logic             wr_en_i;
  logic             wr_acc_i;
  logic [LANES-1:0] wr_mask_i;
  logic [AW-1:0]    wr_addr_i;
  logic [WW-1:0]    wr_data_i;
  logic             rd_en_i;
  logic [AW-1:0]    rd_addr_i;
  logic [WW-1:0]    rd_data_o;
  logic             rd_valid_o;
  logic             sat_flag_o;

  always #5 clk = ~clk;

  fmo_acc_ram #(
    .PX_W (PX_W),
    .LANES(LANES),
    .DEPTH(DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .clr_i     (clr_i),
    .busy_o    (busy_o),
    .wr_en_i   (wr_en_i),
    .wr_acc_i  (wr_acc_i),
    .wr_mask_i (wr_mask_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (rd_en_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .rd_valid_o(rd_valid_o),
    .sat_flag_o(sat_flag_o)
  );

  typedef struct {
    int            addr;
    logic [WW-1:0] data;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   model [DEPTH][LANES];
  int   clear_left = 0;
  bit   msat = 1'b0;
  bit   msat_pend = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack_word(input int a);
    logic [WW-1:0] w;
    int            v;
    w = '0;
    for (int i = 0; i < LANES; i++) begin
      v = model[a][i];
      w[i*PX_W +: PX_W] = v[PX_W-1:0];
    end
    return w;
  endfunction

  // Applies one write to the model; returns 1 if any lane clamped.
  function automatic bit apply_write(input int a, input logic [LANES-1:0] m, input bit acc,
                                     input logic [WW-1:0] d);
    bit                      s;
    logic signed [PX_W-1:0]  dl;
    int                      nv;
    s = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) begin
        dl = d[i*PX_W +: PX_W];
        nv = int'(dl);
        if (acc) begin
          nv = model[a][i] + nv;
          if (nv > PxMax) begin
            nv = PxMax;
            s  = 1'b1;
          end else if (nv < PxMin) begin
            nv = PxMin;
            s  = 1'b1;
          end
        end
        model[a][i] = nv;
      end
    end
    return s;
  endfunction

  // Monitor: every rd_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rd_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_valid: got unexpected pulse, expected none");
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("rd_data[%0d]", mon_e.addr), rd_data_o, mon_e.data);
      end
    end
  end

  // One clock: drive inputs, update the model for the edge, then check flags.
  task automatic cyc(input bit r, input bit c, input bit we, input bit acc,
                     input logic [LANES-1:0] m, input int wa, input logic [WW-1:0] wd,
                     input bit re, input int ra);
    bit   accept;
    exp_t e;
    logic [31:0] wa_v;
    logic [31:0] ra_v;
    wa_v      = wa;
    ra_v      = ra;
    rst_i     = r;
    clr_i     = c;
    wr_en_i   = we;
    wr_acc_i  = acc;
    wr_mask_i = m;
    wr_addr_i = wa_v[AW-1:0];
    wr_data_i = wd;
    rd_en_i   = re;
    rd_addr_i = ra_v[AW-1:0];
    accept = !r && !c && (clear_left == 0);
    if (re && accept) begin
      e.addr = ra;
      e.data = pack_word(ra);
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      clear_left = 0;
      msat       = 1'b0;
      msat_pend  = 1'b0;
    end else if (clear_left > 0) begin
      for (int l = 0; l < LANES; l++) model[DEPTH - clear_left][l] = 0;
      clear_left--;
    end else if (c) begin
      msat       = 1'b0;
      msat_pend  = 1'b0;
      clear_left = DEPTH;
    end else begin
      msat      = msat | msat_pend;
      msat_pend = 1'b0;
      if (we) msat_pend = apply_write(wa, m, acc, wd);
    end
    #1;
    check("busy", WW'(busy_o), WW'(clear_left > 0));
    check("sat_flag", WW'(sat_flag_o), WW'(msat));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 0, '0, 1'b0, 0);
  endtask

  task automatic wr(input int a, input logic [WW-1:0] d, input logic [LANES-1:0] m,
                    input bit acc);
    cyc(1'b0, 1'b0, 1'b1, acc, m, a, d, 1'b0, 0);
  endtask

  task automatic rd(input int a);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 0, '0, 1'b1, a);
  endtask

  task automatic wait_clear();
    for (int i = 0; i < DEPTH + 4 && clear_left > 0; i++) idle();
    check("clear_done", WW'(clear_left > 0), '0);
  endtask

  task automatic do_clear();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 0, '0, 1'b0, 0);
    wait_clear();
  endtask

  function automatic logic [WW-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
          int'($urandom_range(0, DEPTH - 1)), rnd_word(), 1'($urandom),
          int'($urandom_range(0, DEPTH - 1)));
    end
    check("reset_rd_valid", WW'(rd_valid_o), '0);
    check("reset_rd_data", rd_data_o, '0);
    idle();
    do_clear();

    // Fill, then clr with a same-cycle write and read that must both be dropped
    for (int a = 0; a < DEPTH; a++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, a, rnd_word(), 1'($urandom),
          int'($urandom_range(0, DEPTH - 1)));
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 9, 64'h1234_5678_9ABC_DEF0, 1'b1, 9);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
          int'($urandom_range(0, DEPTH - 1)), rnd_word(), 1'($urandom),
          int'($urandom_range(0, DEPTH - 1)));
    end
    check("clear_ended", WW'(busy_o), '0);
    for (int a = 0; a < DEPTH; a++) rd(a);

    // Plain write; same-cycle read returns the old word, next-cycle read the new one
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 5, 64'h0004_0003_0002_0001, 1'b1, 5);
    rd(5);
    idle();

    // Accumulate chain through stage-2 forwarding
    do_clear();
    for (int i = 0; i < 3; i++) wr(7, 64'h0000_0000_0000_000A, 4'b0001, 1'b1);
    rd(7);
    idle();

    // Mask and saturation
    wr(3, {4{16'sd32000}}, 4'hF, 1'b0);
    wr(3, {4{16'sd1000}}, 4'b0101, 1'b1);
    idle();
    rd(3);
    idle();
    check("sat_set", WW'(sat_flag_o), WW'(1));
    do_clear();

    // Random traffic on a few addresses to stress forwarding and saturation
    for (int i = 0; i < 1500; i++) begin
      cyc(1'b0, ($urandom_range(0, 399) == 0), 1'($urandom), 1'($urandom), 4'($urandom),
          int'($urandom_range(0, 7)), rnd_word(), 1'($urandom),
          int'($urandom_range(0, 7)));
    end
    wait_clear();
    idle();

    // Reset mid-clear at counter 10
    for (int a = 0; a < DEPTH; a++) wr(a, {4{16'h0055}}, 4'hF, 1'b0);
    idle();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 0, '0, 1'b0, 0);
    for (int i = 0; i < 10; i++) idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 0, '0, 1'b0, 0);
    check("rst_mid_clear_busy", WW'(busy_o), '0);
    for (int a = 0; a < DEPTH; a++) rd(a);

    for (int i = 0; i < 3; i++) idle();
    check("reads_outstanding", WW'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
